// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The stage-control bundle orders the enables as the pipeline registers consume them.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    ERROR    = 2'd3
  } ctrl_state_e;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_bubble;
    logic exmem_write;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_FREEZE = 6'b000000;
  localparam stage_ctrl_t CTRL_PASS   = 6'b110101;
  localparam stage_ctrl_t CTRL_SQUASH = 6'b111111;
  localparam stage_ctrl_t CTRL_LDUSE  = 6'b000111;
  localparam stage_ctrl_t CTRL_ERROR  = 6'b000010;
  localparam stage_ctrl_t CTRL_RESET  = 6'b001010;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard compare between the load in ID/EX and the
// source operands of the instruction in IF/ID. Register zero never hazards.
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_rd,
  input  logic [4:0] ex_rt,
  output logic       hazard
);

  logic [4:0] src_reg [2];
  logic [1:0] src_used;
  logic [1:0] src_match;

  assign src_reg[0] = id_rs;
  assign src_reg[1] = id_rt;
  assign src_used   = {id_uses_rt, 1'b1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_match[gi] = src_used[gi] && (ex_rt == src_reg[gi]);
    end
  endgenerate

  assign hazard = ex_mem_rd && (ex_rt != REG_ZERO) && (|src_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencing: load-use stall, branch flush, memory freeze
// and sticky memory timeout. Optional counters: PIPELINE_HAZARD_CTRL_PERF_EN.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 64,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_rd,
  input  logic [4:0] ex_rt,
  input  logic       ex_branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_write,
  output logic       idex_bubble,
  output logic       exmem_write,
  output logic       mem_timeout,
  output logic [1:0] ctrl_state
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count,
  output logic [15:0] load_use_count
`endif
);

  localparam int          WAIT_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [1:0]  FLUSH_LAST  = 2'(FLUSH_CYCLES - 1);
  localparam bit          MULTI_FLUSH = (FLUSH_CYCLES > 1);

  ctrl_state_e       state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [1:0]        flush_cnt_reg, flush_cnt_next;
  logic              timeout_reg, timeout_next;

  logic        hazard;
  logic        freeze_req;
  logic        run_freeze;
  logic        branch_acc;
  logic        load_use_acc;
  stage_ctrl_t ctrl;

  load_use_detect u_load_use_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_mem_rd  (ex_mem_rd),
    .ex_rt      (ex_rt),
    .hazard     (hazard)
  );

  assign freeze_req = mem_req && !mem_ready;
  // Once waiting, only mem_ready releases the freeze, whatever mem_req does.
  assign run_freeze = (state_reg == MEM_WAIT) ? !mem_ready : freeze_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= '0;
      flush_cnt_reg <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
      timeout_reg   <= timeout_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    timeout_next   = timeout_reg;
    case (state_reg)
      RUN, MEM_WAIT: begin
        if (run_freeze) begin
          if (state_reg == RUN) begin
            state_next    = MEM_WAIT;
            wait_cnt_next = WAIT_W'(1);
          end else if (wait_cnt_reg == WAIT_LAST) begin
            state_next   = ERROR;
            timeout_next = 1'b1;
          end else begin
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
          end
        end else begin
          wait_cnt_next = '0;
          state_next    = RUN;
          if (ex_branch_taken && MULTI_FLUSH) begin
            state_next     = FLUSH;
            flush_cnt_next = 2'd1;
          end
        end
      end
      FLUSH: begin
        if (!freeze_req) begin
          if (flush_cnt_reg == FLUSH_LAST) begin
            state_next     = RUN;
            flush_cnt_next = '0;
          end else begin
            flush_cnt_next = flush_cnt_reg + 2'd1;
          end
        end
      end
      default: state_next = ERROR;
    endcase
  end

  always_comb begin
    ctrl         = CTRL_FREEZE;
    branch_acc   = 1'b0;
    load_use_acc = 1'b0;
    case (state_reg)
      RUN, MEM_WAIT: begin
        // Branch outranks load-use: the dependent instruction is being squashed.
        if (run_freeze) begin
          ctrl = CTRL_FREEZE;
        end else if (ex_branch_taken) begin
          ctrl       = CTRL_SQUASH;
          branch_acc = 1'b1;
        end else if (hazard) begin
          ctrl         = CTRL_LDUSE;
          load_use_acc = 1'b1;
        end else begin
          ctrl = CTRL_PASS;
        end
      end
      FLUSH:   ctrl = freeze_req ? CTRL_FREEZE : CTRL_SQUASH;
      default: ctrl = CTRL_ERROR;
    endcase
    if (!rst_n) begin
      ctrl         = CTRL_RESET;
      branch_acc   = 1'b0;
      load_use_acc = 1'b0;
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_write  = ctrl.idex_write;
  assign idex_bubble = ctrl.idex_bubble;
  assign exmem_write = ctrl.exmem_write;
  assign mem_timeout = timeout_reg;
  assign ctrl_state  = state_reg;

`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cycles_reg;
  logic [15:0] flush_count_reg;
  logic [15:0] load_use_count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_reg   <= '0;
      flush_count_reg    <= '0;
      load_use_count_reg <= '0;
    end else begin
      if (!ctrl.pc_write && (stall_cycles_reg != '1))
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (branch_acc && (flush_count_reg != '1))
        flush_count_reg <= flush_count_reg + 16'd1;
      if (load_use_acc && (load_use_count_reg != '1))
        load_use_count_reg <= load_use_count_reg + 16'd1;
    end
  end

  assign stall_cycles   = stall_cycles_reg;
  assign flush_count    = flush_count_reg;
  assign load_use_count = load_use_count_reg;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl: two instances (long
// timeout / 3-cycle flush, and short timeout / 1-cycle flush) share stimulus.
module tb_pipeline_hazard_ctrl;

  localparam int MT_A = 8;
  localparam int FC_A = 3;
  localparam int MT_B = 4;
  localparam int FC_B = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_rd, ex_branch_taken, mem_req, mem_ready;

  logic       pc_w [2], ifid_w [2], ifid_f [2], idex_w [2], idex_b [2], exmem_w [2];
  logic       to [2];
  logic [1:0] st [2];
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_c [2];
  logic [15:0] flush_c [2];
  logic [15:0] lu_c [2];
`endif

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT_A), .FLUSH_CYCLES(FC_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_rd(ex_mem_rd), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_w[0]), .ifid_write(ifid_w[0]), .ifid_flush(ifid_f[0]),
    .idex_write(idex_w[0]), .idex_bubble(idex_b[0]), .exmem_write(exmem_w[0]),
    .mem_timeout(to[0]), .ctrl_state(st[0])
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
    , .stall_cycles(stall_c[0]), .flush_count(flush_c[0]), .load_use_count(lu_c[0])
`endif
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT_B), .FLUSH_CYCLES(FC_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_rd(ex_mem_rd), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_w[1]), .ifid_write(ifid_w[1]), .ifid_flush(ifid_f[1]),
    .idex_write(idex_w[1]), .idex_bubble(idex_b[1]), .exmem_write(exmem_w[1]),
    .mem_timeout(to[1]), .ctrl_state(st[1])
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
    , .stall_cycles(stall_c[1]), .flush_count(flush_c[1]), .load_use_count(lu_c[1])
`endif
  );

  // Reference model: counts frozen cycles and remaining flush cycles directly.
  bit waiting [2];
  int frozen_run [2];
  int flush_left [2];
  bit dead [2];
  int m_stall [2];
  int m_flush [2];
  int m_lu [2];

  int total = 0;
  int bad = 0;
  int txn = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input int i);
    int mt, fc;
    bit hz, frz, br_acc, lu_acc;
    logic [5:0] ev, got_v;
    logic [1:0] es;
    mt = (i == 0) ? MT_A : MT_B;
    fc = (i == 0) ? FC_A : FC_B;
    es = dead[i] ? 2'd3 : (flush_left[i] > 0) ? 2'd2 : waiting[i] ? 2'd1 : 2'd0;
    check($sformatf("state[%0d]", i), 32'(st[i]), 32'(es));
    check($sformatf("timeout[%0d]", i), 32'(to[i]), 32'(dead[i]));
`ifdef PIPELINE_HAZARD_CTRL_PERF_EN
    check($sformatf("stall_cnt[%0d]", i), stall_c[i], 32'(m_stall[i]));
    check($sformatf("flush_cnt[%0d]", i), 32'(flush_c[i]), 32'(m_flush[i]));
    check($sformatf("lu_cnt[%0d]", i), 32'(lu_c[i]), 32'(m_lu[i]));
`endif
    hz = ex_mem_rd && (ex_rt != 5'd0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    br_acc = 1'b0;
    lu_acc = 1'b0;
    // Vector order: pc, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write
    if (!rst_n) begin
      ev = 6'b001010;
    end else if (dead[i]) begin
      ev = 6'b000010;
    end else if (flush_left[i] > 0) begin
      if (mem_req && !mem_ready) ev = 6'b000000;
      else begin
        ev = 6'b111111;
        flush_left[i]--;
      end
    end else begin
      frz = waiting[i] ? !mem_ready : (mem_req && !mem_ready);
      if (frz) begin
        ev = 6'b000000;
        waiting[i] = 1'b1;
        frozen_run[i]++;
        if (frozen_run[i] == mt) dead[i] = 1'b1;
      end else begin
        waiting[i] = 1'b0;
        frozen_run[i] = 0;
        if (ex_branch_taken) begin
          ev = 6'b111111;
          flush_left[i] = fc - 1;
          br_acc = 1'b1;
        end else if (hz) begin
          ev = 6'b000111;
          lu_acc = 1'b1;
        end else begin
          ev = 6'b110101;
        end
      end
    end
    got_v = {pc_w[i], ifid_w[i], ifid_f[i], idex_w[i], idex_b[i], exmem_w[i]};
    check($sformatf("ctrl[%0d]", i), 32'(got_v), 32'(ev));
    if (!rst_n) begin
      waiting[i] = 1'b0; frozen_run[i] = 0; flush_left[i] = 0; dead[i] = 1'b0;
      m_stall[i] = 0; m_flush[i] = 0; m_lu[i] = 0;
    end else begin
      if (!ev[5]) m_stall[i]++;
      if (br_acc) m_flush[i]++;
      if (lu_acc) m_lu[i]++;
    end
  endtask

  task automatic cyc(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urt, input logic mrd, input logic [4:0] ert,
                     input logic br, input logic req, input logic rdy);
    @(negedge clk);
    rst_n = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_rd = mrd;
    ex_rt = ert; ex_branch_taken = br; mem_req = req; mem_ready = rdy;
    #1;
    $display("txn %0d rst_n=%b rs=%0d rt=%0d urt=%b mrd=%b ert=%0d br=%b req=%b rdy=%b | a st=%0d ctl=%b%b%b%b%b%b | b st=%0d ctl=%b%b%b%b%b%b",
             txn, r, rs, rt, urt, mrd, ert, br, req, rdy,
             st[0], pc_w[0], ifid_w[0], ifid_f[0], idex_w[0], idex_b[0], exmem_w[0],
             st[1], pc_w[1], ifid_w[1], ifid_f[1], idex_w[1], idex_b[1], exmem_w[1]);
    model_step(0);
    model_step(1);
    txn++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      waiting[i] = 0; frozen_run[i] = 0; flush_left[i] = 0; dead[i] = 0;
      m_stall[i] = 0; m_flush[i] = 0; m_lu[i] = 0;
    end
    rst_n = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_mem_rd = 0;
    ex_rt = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    repeat (2) @(posedge clk);

    idle(1);
    // Load-use on rs, then the bubble leaves ex_mem_rd clear
    cyc(1, 8, 0, 0, 1, 8, 0, 0, 0);
    cyc(1, 8, 0, 0, 0, 8, 0, 0, 0);
    // Register zero and unused rt never stall; used rt does
    cyc(1, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 3, 9, 0, 1, 9, 0, 0, 0);
    cyc(1, 3, 9, 1, 1, 9, 0, 0, 0);
    // Branch with simultaneous load-use
    cyc(1, 8, 0, 0, 1, 8, 1, 0, 0);
    idle(3);
    // Memory wait five cycles then ready
    repeat (5) cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(3);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // Reset inside FLUSH
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // Freeze during FLUSH, then long timeout on both instances
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    repeat (10) cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 39) != 0),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4),
          5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 2),
          ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequencing controller for the five-stage MIPS pipeline registers (IF/ID, ID/EX, EX/MEM). It decides every cycle whether each stage register loads, holds or is bubbled:
- load-use stall;
- taken-branch flush;
- whole-pipeline freeze while data memory is not ready;
- a sticky timeout when memory never answers.

It sits beside the pipeline registers and drives their write-enable and flush inputs. It also drives the PC write-enable.

## Interface
Parameters:
- MEM_TIMEOUT, 64: maximum consecutive not-ready cycles tolerated in MEM_WAIT (legal range 2..65535).
- FLUSH_CYCLES, 1: number of cycles IF/ID is flushed per taken branch (legal range 1..4).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset. One clock, one reset.
- id_rs  in  5  Rs field of the instruction in IF/ID.
- id_rt  in  5  Rt field of the instruction in IF/ID.
- id_uses_rt  in  1  instruction in IF/ID reads Rt as a source.
- ex_mem_rd  in  1  Mem_Rd control held in ID/EX.
- ex_rt  in  5  Rt (load destination) held in ID/EX.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- mem_req  in  1  EX/MEM holds a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_write  out  1  ID/EX load enable.
- idex_bubble  out  1  ID/EX loads all-zero control signals (ALU_Op through Mem_To_Reg = 0).
- exmem_write  out  1  EX/MEM and MEM/WB load enable.
- mem_timeout  out  1  sticky memory-timeout error flag.
- ctrl_state  out  2  current state encoding.

## Operation
States and encoding: RUN=0, MEM_WAIT=1, FLUSH=2, ERROR=3.

All outputs are combinational decodes of the current state and inputs. Only the state, the counters and mem_timeout are registered.

Load-use hazard is defined as: ex_mem_rd and ex_rt != 0 and (ex_rt == id_rs, or id_uses_rt and ex_rt == id_rt).

RUN priority, highest first:
1. **Freeze.** Condition: mem_req and not mem_ready. All write enables are 0 and there are no flushes. Next state MEM_WAIT; wait counter is set to 1.
2. **Taken branch.** Condition: ex_branch_taken. ifid_flush=1 and idex_bubble=1; all writes are 1. If FLUSH_CYCLES>1, next state is FLUSH with the flush counter set to 1. A load-use hazard in the same cycle is ignored, because the dependent instruction is flushed.
3. **Load-use.** pc_write=0, ifid_write=0, idex_bubble=1; idex_write=1 and exmem_write=1. This yields exactly one bubble, because the next cycle sees ex_mem_rd=0.
4. **Otherwise.** All writes are 1; ifid_flush=0 and idex_bubble=0.

MEM_WAIT:
- While mem_ready=0: freeze as above, and the wait counter increments.
- Counter == MEM_TIMEOUT-1 and mem_ready=0: next state ERROR and mem_timeout is set.
- mem_ready=1: outputs are decoded exactly as RUN with the freeze term false (so branch and load-use still apply). Next state is RUN, or FLUSH as in RUN.

FLUSH:
- pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1.
- The counter increments. When it equals FLUSH_CYCLES-1, the next state is RUN.
- A freeze request overrides: outputs freeze and the state stays FLUSH.

ERROR:
- All write enables 0, idex_bubble=1, mem_timeout=1.
- Left only by reset.

## Timing
- Decision latency is 0 cycles: outputs respond to inputs in the same cycle.
- State changes take effect at the next rising clk edge.
- Reset is sampled on the rising edge. While rst_n=0, outputs are forced to: pc_write=ifid_write=idex_write=exmem_write=0, ifid_flush=1, idex_bubble=1.
- After the reset edge: state RUN, all counters 0, mem_timeout=0, ctrl_state=0.
- Reset mid-MEM_WAIT or mid-FLUSH abandons the operation; there is no residual flush afterwards.
- Counters are sized ceil(log2(MEM_TIMEOUT+1)) bits and 2 bits respectively. Neither wraps.

## Configuration
- The macro PIPELINE_HAZARD_CTRL_PERF_EN adds three outputs:
  - stall_cycles (out, 32): counts cycles with pc_write=0 outside reset.
  - flush_count (out, 16): counts taken branches accepted.
  - load_use_count (out, 16): counts load-use bubbles.
  - All three are reset to 0, saturate at all-ones, and update on the same edge as the event.
- Without the macro these ports and their registers do not exist; all other behaviour is identical.

## Structure
- The shared package holds:
  - the state enum (RUN, MEM_WAIT, FLUSH, ERROR) and its 2-bit encoding;
  - the register-zero constant 5'd0;
  - the NOP instruction constant 32'h0000_0000.
- One sub-module, load_use_detect, holds the purely combinational hazard compare. The FSM and counters stay in the top module.

## Test plan
- **Load-use.** ex_mem_rd=1, ex_rt=8, id_rs=8 → pc_write=0, ifid_write=0, idex_bubble=1 for exactly one cycle; the next cycle all writes are 1.
- **No hazard on register zero.** ex_rt=0, id_rs=0, ex_mem_rd=1 → no stall. Separately, id_uses_rt=0 with ex_rt=id_rt=9 → no stall.
- **Branch overrides load-use.** ex_branch_taken=1 in the same cycle as a load-use hazard → ifid_flush=1, idex_bubble=1, pc_write=1. With FLUSH_CYCLES=3, ifid_flush stays high for 3 cycles total.
- **Memory wait then ready.** mem_req=1, mem_ready=0 for 5 cycles, then 1 → all writes 0 for 5 cycles, ctrl_state=1; in the ready cycle exmem_write=1 and state returns to 0.
- **Timeout and reset.** MEM_TIMEOUT=4, mem_ready held 0 → ERROR entered after 4 frozen cycles, mem_timeout=1 and stays 1. Pulsing rst_n=0 for one edge → ctrl_state=0, mem_timeout=0.
- **Reset inside FLUSH.** rst_n=0 during FLUSH → outputs forced to the reset values; after release, RUN with no extra flush. With PIPELINE_HAZARD_CTRL_PERF_EN, the counters read 0.
